jtag_host: RTL

Host-side JTAG driver: generates TCK/TMS/TDI from the system clock and samples TDO, so on-board logic or a test harness can drive any IEEE 1149.1 TAP. It accepts one command at a time: a TAP reset, an IR scan or a DR scan. For scans it returns the bits captured from TDO. It is the initiator counterpart of the board's TAP controller and instruction/data registers, and it connects to their TMS/TCK/TDI/TDO pins.

---
 rtl/jtag_host.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_host.sv
// jtag_host: host-side JTAG driver. Sequences TCK/TMS/TDI for TAP reset,
// IR scans and DR scans, and captures TDO into rsp_data (LSB = first bit).
module jtag_host #(
  parameter  int CLK_DIV = 2,
  parameter  int MAX_LEN = 32,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_tlr,
  input  logic               cmd_ir,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  // Phase counter spans one full TCK period; bit counter must also hold the
  // 6-bit INIT sequence index even when MAX_LEN is tiny.
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = (LW > 3) ? LW : 3;
  localparam logic [CW-1:0] PH_RISE = CW'(CLK_DIV);
  localparam logic [CW-1:0] PH_END  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_NAV, S_SHIFT, S_POST, S_DONE
  } state_t;

  state_t             state, state_n, seq_next;
  logic [CW-1:0]      cnt, cnt_n;
  logic [BW-1:0]      bcnt, bcnt_n, bit_last;
  logic [BW-1:0]      len, len_n;
  logic               is_ir, ir_n, is_scan, scan_n, rsp_en, rsp_en_n;
  logic [MAX_LEN-1:0] sh, sh_n, cap, cap_n, wsel, wsel_n;
  logic               tck_q, tck_n, tms_q, tms_n, tdi_q, tdi_n;
  logic               rsp_valid_q, rsp_valid_n;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_n;
  logic               bit_tms;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  // Per-state TMS for the current bit, index of the state's last bit, and successor
  always_comb begin
    bit_tms  = 1'b0;
    bit_last = '0;
    seq_next = S_DONE;
    case (state)
      S_INIT: begin
        bit_tms  = (bcnt != BW'(5));
        bit_last = BW'(5);
        seq_next = S_DONE;
      end
      S_NAV: begin
        // IR: Select-DR, Select-IR, Capture-IR, Shift-IR; DR skips Select-IR
        bit_tms  = is_ir ? (bcnt < BW'(2)) : (bcnt == '0);
        bit_last = is_ir ? BW'(3) : BW'(2);
        seq_next = S_SHIFT;
      end
      S_SHIFT: begin
        bit_tms  = (bcnt == len - BW'(1));
        bit_last = len - BW'(1);
        seq_next = S_POST;
      end
      S_POST: begin
        bit_tms  = (bcnt == '0);
        bit_last = BW'(1);
        seq_next = S_DONE;
      end
      default: ;
    endcase
  end

  // Next-state and datapath: command accept, TCK bit engine, completion
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bcnt_n      = bcnt;
    len_n       = len;
    ir_n        = is_ir;
    scan_n      = is_scan;
    rsp_en_n    = rsp_en;
    sh_n        = sh;
    cap_n       = cap;
    wsel_n      = wsel;
    tck_n       = tck_q;
    tms_n       = tms_q;
    tdi_n       = tdi_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    case (state)
      S_IDLE: begin
        tck_n = 1'b0;
        tdi_n = 1'b0;
        if (cmd_valid) begin
          cnt_n    = '0;
          bcnt_n   = '0;
          rsp_en_n = 1'b1;
          if (cmd_tlr) begin
            scan_n  = 1'b0;
            state_n = S_INIT;
          end else begin
            scan_n  = 1'b1;
            ir_n    = cmd_ir;
            sh_n    = cmd_data;
            cap_n   = '0;
            wsel_n  = MAX_LEN'(1);
            state_n = S_NAV;
            if (cmd_len == '0)
              len_n = BW'(1);
            else if (cmd_len > LW'(MAX_LEN))
              len_n = BW'(MAX_LEN);
            else
              len_n = BW'(cmd_len);
          end
        end
      end
      S_DONE: begin
        tck_n       = 1'b0;
        rsp_valid_n = rsp_en;
        if (rsp_en && is_scan) rsp_data_n = cap;
        state_n     = S_IDLE;
      end
      default: begin
        // Low phase start: TMS/TDI change only here, TCK falls
        if (cnt == '0) begin
          tck_n = 1'b0;
          tms_n = bit_tms;
          tdi_n = 1'b0;
          if (state == S_SHIFT) begin
            tdi_n = sh[0];
            sh_n  = sh >> 1;
          end
        end
        // Rising TCK: TDO has been stable through the low phase
        if (cnt == PH_RISE) begin
          tck_n = 1'b1;
          if (state == S_SHIFT) begin
            if (TDO) cap_n = cap | wsel;
            wsel_n = wsel << 1;
          end
        end
        if (cnt == PH_END) begin
          cnt_n = '0;
          if (bcnt == bit_last) begin
            bcnt_n  = '0;
            state_n = seq_next;
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  // State and datapath registers; reset restarts the INIT sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      bcnt        <= '0;
      len         <= '0;
      is_ir       <= 1'b0;
      is_scan     <= 1'b0;
      rsp_en      <= 1'b0;
      sh          <= '0;
      cap         <= '0;
      wsel        <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bcnt        <= bcnt_n;
      len         <= len_n;
      is_ir       <= ir_n;
      is_scan     <= scan_n;
      rsp_en      <= rsp_en_n;
      sh          <= sh_n;
      cap         <= cap_n;
      wsel        <= wsel_n;
      tck_q       <= tck_n;
      tms_q       <= tms_n;
      tdi_q       <= tdi_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
    end
  end

endmodule
